// File: rtl/riscv_data_mem.sv
// riscv_data_mem: word-organised LSU data memory with a fixed-latency handshake.
// A request is accepted in IDLE, waits WAIT_CYCLES in BUSY, commits on the edge
// entering RESP and pulses mem_ready_o for one cycle.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range accesses flag mem_err_o,
// read as zero and never write; when undefined, addresses wrap modulo DEPTH).
module riscv_data_mem #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_accept;
  logic            w_commit;

  logic            r_we;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wd;
  logic            r_oor;

  logic            w_oor_in;
  logic            w_sel_we;
  logic [3:0]      w_sel_be;
  logic [AW-1:0]   w_sel_idx;
  logic [31:0]     w_sel_wd;
  logic            w_sel_oor;
  logic [31:0]     w_old;
  logic [31:0]     w_merged;

  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_rd;
  logic            r_ready;
  logic            r_err;

`ifdef DMEM_RANGE_CHECK_EN
  // Any set bit above the index field means the word lies beyond storage.
  assign w_oor_in = |mem_addr_i[31:AW+2];
  logic w_unused_addr;
  assign w_unused_addr = ^mem_addr_i[1:0];
`else
  // Upper address bits are dropped so accesses alias modulo DEPTH.
  assign w_oor_in = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};
`endif

  // State and wait-counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; commit is flagged on the transition into RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req_i) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = '0;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CW'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Request capture at accept time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we  <= 1'b0;
      r_be  <= '0;
      r_idx <= '0;
      r_wd  <= '0;
      r_oor <= 1'b0;
    end else if (w_accept) begin
      r_we  <= mem_we_i;
      r_be  <= mem_be_i;
      r_idx <= mem_addr_i[AW+1:2];
      r_wd  <= mem_wd_i;
      r_oor <= w_oor_in;
    end
  end

  // With zero wait states the commit edge is the accept edge, so use live inputs.
  always_comb begin
    if (r_state == IDLE) begin
      w_sel_we  = mem_we_i;
      w_sel_be  = mem_be_i;
      w_sel_idx = mem_addr_i[AW+1:2];
      w_sel_wd  = mem_wd_i;
      w_sel_oor = w_oor_in;
    end else begin
      w_sel_we  = r_we;
      w_sel_be  = r_be;
      w_sel_idx = r_idx;
      w_sel_wd  = r_wd;
      w_sel_oor = r_oor;
    end
  end

  // Byte-lane merge of write data over the current word.
  always_comb begin
    w_old    = r_mem[w_sel_idx];
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_sel_be[i]) begin
        w_merged[8*i +: 8] = w_sel_wd[8*i +: 8];
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_commit && w_sel_we && !w_sel_oor) begin
      r_mem[w_sel_idx] <= w_merged;
    end
  end

  // Response registers: data held until next commit, ready/err pulse in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_commit;
      r_err   <= w_commit & w_sel_oor;
      if (w_commit) begin
        if (w_sel_oor) begin
          r_rd <= '0;
        end else if (w_sel_we) begin
          r_rd <= w_merged;
        end else begin
          r_rd <= w_old;
        end
      end
    end
  end

  assign mem_rd_o    = r_rd;
  assign mem_ready_o = r_ready;
  assign mem_err_o   = r_err;

endmodule
